dispatch: RTL and testbench
===========================

# dispatch

Dispatch stage between rename and the issue queues/ROB. Each cycle it takes the longest in-order prefix of the rename output that fits in ROB and issue-queue capacity and asserts `rename` for it. It annotates each accepted op with source-operand readiness from a physical-register busy table, then presents the group registered to the issue queues one cycle later. The busy table is maintained here: set on dispatch of a destination, cleared on writeback.

## Interface
Parameters:
- `rwd`, 2: rename/dispatch width.
- `wwd`, 2: writeback ports.
- `nfu`, 4: issue queues; queue index = `fu[$clog2(nfu)-1:0]`.
- `prnum`, 64: physical registers.
- `robsz`, 32: ROB entries.
- `iqsz`, 8: entries per issue queue.

Ports:
- `clk` in, 1: clock.
- `rst` in, 1: reset, asynchronous, active-low.
- `red_bundle` in, `red_bundle_t`: redirect; active when `opid[15]`; `rollback` flag.
- `ren_bundle` in, `[rwd] ren_bundle_t`: renamed ops; slot valid when `opid[15]`.
- `rename` out, `[rwd]`: slot consumed this cycle.
- `rob_free` in, `$clog2(robsz)+1`: free ROB entries, excluding the group held in the output register.
- `iq_free` in, `[nfu][$clog2(iqsz):0]`: free entries per queue, excluding the held group.
- `wb_valid` in, `[wwd]`: writeback valid.
- `wb_prd` in, `[wwd][$clog2(prnum)-1:0]`: writeback physical destination.
- `dis_bundle` out, `[rwd] ren_bundle_t`: dispatched group; slot valid when `opid[15]`.
- `dis_rdy` out, `[rwd][1:0]`: readiness of `prsa[0]` and `prsa[1]` at dispatch.

## Operation
- **Busy table**
  - `prnum` bits; reset value all 0 (ready). Bit 0 is hard-wired 0.
  - Writeback clears `busy[wb_prd[k]]` when `wb_valid[k]`.
  - An accepted slot with nonzero `prda[1]` sets `busy[prda[1]]`.
  - Set and clear of the same index in one cycle: set wins.
- **Acceptance, combinational in cycle t**
  - Walk slots i = 0..rwd-1. Stop at the first slot that is invalid or fails a check.
  - Checks: cumulative accepted count ≤ `rob_free` − held; cumulative count for the target queue ≤ `iq_free[q]` − held[q].
  - "held" = valid slots currently in the output register, total and per queue.
  - `rename[i]` = 1 for accepted slots, else 0.
- **Suppression:** no acceptance (`rename` = 0) while `red_bundle.opid[15]` or `red_bundle.rollback`.
- **Readiness of source s of slot i** (ready = 1):
  - The register is `prsa[s] == 0`; or
  - `busy[prsa[s]] == 0` and no earlier accepted slot j < i has `prda[1] == prsa[s]` (nonzero); or
  - It matches a same-cycle `wb_prd` with `wb_valid`, and no earlier accepted slot j < i in the group writes it.
  - The intra-group producer check overrides both busy and writeback.
- **Output register**
  - Latches the accepted slots compacted to slots 0..n-1.
  - Unaccepted slots load `opid = 0`.
  - `dis_rdy` latches the computed readiness.
- **Redirect in cycle t**
  - `dis_bundle[*].opid` is forced 0 combinationally during t. The held group is dropped and does not count as held.
  - The output register loads an empty group.
  - The busy table is not restored. Stale busy bits are harmless: a reallocated register is re-set on redispatch and cleared by its new producer.
- **Downstream:** `dis_bundle` needs no ready handshake; capacity is guaranteed by credits. Issue queues snoop writeback in the cycle they receive `dis_bundle`.

## Timing
- **Reset:** `rename` = 0, `dis_bundle` all `opid` = 0, `dis_rdy` = 0, busy table all 0.
- **Latency:** acceptance at cycle t → `dis_bundle` valid during t+1 for exactly one cycle.
- **Writeback:** a writeback at t is visible to acceptance at t through the bypass. A writeback at t+1 is the issue queue's responsibility.
- **Busy set at t:** visible in the table from t+1; visible in t only through the intra-group check.
- **Throughput:** rwd/cycle when credits allow.
- **Empty/full:**
  - `rob_free` − held = 0 → no acceptance.
  - Credit arithmetic is unsigned at `$clog2(size)+1` bits. Held ≤ free is guaranteed by the consumer; underflow is treated as 0 available.

## Test plan
- **Reset release, ROB credit, per-queue credit, intra-group dependency**
  - Setup: `rob_free` = 32, all `iq_free` = 8. Slot0: `prsa` = {0,0}, `prda[1]` = 5. Slot1: `prsa[0]` = 5, `fu` = 1.
  - Response: `rename` = 2'b11; at t+1 `dis_rdy[0]` = 2'b11, `dis_rdy[1][0]` = 0, `busy[5]` = 1.
- **Writeback clears busy**
  - Stimulus: `wb_valid` = 1, `wb_prd` = 5 at t+2. Next op reads `prsa[0]` = 5 in the same cycle.
  - Response: `dis_rdy` bit = 1; `busy[5]` = 0 at t+3.
- **Credit limit including held group**
  - Stimulus: `iq_free[2]` = 1, held group has one op for queue 2, two new ops for queue 2.
  - Response: `rename` = 0. Next cycle, with held cleared and `iq_free[2]` = 1: `rename` = 2'b01.
- **In-order stop**
  - Stimulus: slot0 targets full queue 3, slot1 targets empty queue 0.
  - Response: `rename` = 2'b00.
- **Redirect and rollback**
  - Stimulus: redirect during a held valid group.
  - Response: `dis_bundle` `opid` = 0 that cycle, `rename` = 0, next cycle empty.
  - Stimulus: rollback asserted for 3 cycles.
  - Response: `rename` = 0 throughout.
- **Asynchronous reset mid-stream**
  - Stimulus: `rst` low mid-stream with busy bits set.
  - Response: outputs and busy table cleared immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dispatch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dispatch : rename-to-issue dispatch stage with credit-limited in-order   |
// | acceptance, physical-register busy table and registered output group.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+

package dispatch_pkg;
   localparam int c_prw = 6;

   typedef struct packed {
      logic [15:0] opid;
      logic        rollback;
   } red_bundle_t;

   typedef struct packed {
      logic [15:0]                opid;
      logic [3:0]                 fu;
      logic [1:0][c_prw-1:0]      prsa;
      logic [1:0][c_prw-1:0]      prda;
   } ren_bundle_t;
endpackage

module dispatch
   import dispatch_pkg::*;
#(
   parameter int rwd   = 2,
   parameter int wwd   = 2,
   parameter int nfu   = 4,
   parameter int prnum = 64,
   parameter int robsz = 32,
   parameter int iqsz  = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  red_bundle_t                          red_bundle,
   input  ren_bundle_t [rwd-1:0]                ren_bundle,
   output logic [rwd-1:0]                       rename,
   input  logic [$clog2(robsz):0]               rob_free,
   input  logic [nfu-1:0][$clog2(iqsz):0]       iq_free,
   input  logic [wwd-1:0]                       wb_valid,
   input  logic [wwd-1:0][$clog2(prnum)-1:0]    wb_prd,
   output ren_bundle_t [rwd-1:0]                dis_bundle,
   output logic [rwd-1:0][1:0]                  dis_rdy
);
   localparam int c_rw = $clog2(robsz) + 1;
   localparam int c_iw = $clog2(iqsz) + 1;
   localparam int c_qw = $clog2(nfu);
   localparam int c_pw = $clog2(prnum);

   logic [prnum-1:0]            r_busy;
   logic [prnum-1:0]            w_busy_nxt;
   ren_bundle_t [rwd-1:0]       r_dis;
   logic [rwd-1:0][1:0]         r_rdy;
   logic [rwd-1:0][1:0]         w_rdy;
   logic [rwd-1:0]              w_acc;
   logic                        w_redir;
   logic                        w_supp;
   logic [c_rw-1:0]             w_held;
   logic [c_rw-1:0]             w_rob_avail;
   logic [nfu-1:0][c_iw-1:0]    w_qheld;
   logic [nfu-1:0][c_iw-1:0]    w_iq_avail;
   logic                        w_unused;

   assign w_redir  = red_bundle.opid[15];
   assign w_supp   = w_redir | red_bundle.rollback | ~rst;
   assign w_unused = ^red_bundle.opid[14:0];

   // A redirected held group is being dropped, so it no longer consumes credit.
   always_comb begin
      w_held  = '0;
      w_qheld = '0;
      for (int i = 0; i < rwd; i++) begin
         if (r_dis[i].opid[15] && !w_redir) begin
            w_held = w_held + c_rw'(1);
            w_qheld[r_dis[i].fu[c_qw-1:0]] = w_qheld[r_dis[i].fu[c_qw-1:0]] + c_iw'(1);
         end
      end
      w_rob_avail = (rob_free > w_held) ? rob_free - w_held : '0;
      for (int q = 0; q < nfu; q++) begin
         w_iq_avail[q] = (iq_free[q] > w_qheld[q]) ? iq_free[q] - w_qheld[q] : '0;
      end
   end

   // Accepted slots always form a prefix, so the output needs no compaction.
   always_comb begin
      logic                     w_stop;
      logic [c_rw-1:0]          w_cnt;
      logic [nfu-1:0][c_iw-1:0] w_qcnt;
      logic [c_qw-1:0]          w_q;
      w_acc  = '0;
      w_stop = w_supp;
      w_cnt  = '0;
      w_qcnt = '0;
      w_q    = '0;
      for (int i = 0; i < rwd; i++) begin
         w_q = ren_bundle[i].fu[c_qw-1:0];
         if (!w_stop && ren_bundle[i].opid[15] && (w_cnt < w_rob_avail) &&
             (w_qcnt[w_q] < w_iq_avail[w_q])) begin
            w_acc[i]    = 1'b1;
            w_cnt       = w_cnt + c_rw'(1);
            w_qcnt[w_q] = w_qcnt[w_q] + c_iw'(1);
         end else begin
            w_stop = 1'b1;
         end
      end
   end

   always_comb begin
      logic [c_pw-1:0] w_p;
      logic            w_prod;
      logic            w_wbm;
      w_rdy  = '0;
      w_p    = '0;
      w_prod = 1'b0;
      w_wbm  = 1'b0;
      for (int i = 0; i < rwd; i++) begin
         for (int s = 0; s < 2; s++) begin
            w_p    = ren_bundle[i].prsa[s];
            w_prod = 1'b0;
            w_wbm  = 1'b0;
            for (int j = 0; j < rwd; j++) begin
               if (j < i && w_acc[j] && ren_bundle[j].prda[1] == w_p) w_prod = 1'b1;
            end
            for (int k = 0; k < wwd; k++) begin
               if (wb_valid[k] && wb_prd[k] == w_p) w_wbm = 1'b1;
            end
            w_rdy[i][s] = (w_p == '0) || (!w_prod && (!r_busy[w_p] || w_wbm));
         end
      end
   end

   // Clears are applied before sets so a same-cycle redispatch keeps the bit set.
   always_comb begin
      w_busy_nxt = r_busy;
      for (int k = 0; k < wwd; k++) begin
         if (wb_valid[k]) w_busy_nxt[wb_prd[k]] = 1'b0;
      end
      for (int i = 0; i < rwd; i++) begin
         if (w_acc[i] && ren_bundle[i].prda[1] != '0) w_busy_nxt[ren_bundle[i].prda[1]] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy <= '0;
         r_dis  <= '0;
         r_rdy  <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         for (int i = 0; i < rwd; i++) begin
            if (w_acc[i]) begin
               r_dis[i] <= ren_bundle[i];
               r_rdy[i] <= w_rdy[i];
            end else begin
               r_dis[i] <= '0;
               r_rdy[i] <= '0;
            end
         end
      end
   end

   always_comb begin
      dis_bundle = r_dis;
      if (w_redir) begin
         for (int i = 0; i < rwd; i++) dis_bundle[i].opid = '0;
      end
   end

   assign rename  = w_acc;
   assign dis_rdy = r_rdy;

endmodule
`default_nettype wire

// File: tb/tb_dispatch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dispatch : scoreboard bench for the dispatch stage.                    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_dispatch;
   import dispatch_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst;
   red_bundle_t          red_bundle;
   ren_bundle_t [1:0]    ren_bundle;
   logic [1:0]           rename;
   logic [5:0]           rob_free;
   logic [3:0][3:0]      iq_free;
   logic [1:0]           wb_valid;
   logic [1:0][5:0]      wb_prd;
   ren_bundle_t [1:0]    dis_bundle;
   logic [1:0][1:0]      dis_rdy;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [31:0] opids;
      logic [3:0]  rdy;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   dispatch dut (
      .clk        (clk),
      .rst        (rst),
      .red_bundle (red_bundle),
      .ren_bundle (ren_bundle),
      .rename     (rename),
      .rob_free   (rob_free),
      .iq_free    (iq_free),
      .wb_valid   (wb_valid),
      .wb_prd     (wb_prd),
      .dis_bundle (dis_bundle),
      .dis_rdy    (dis_rdy)
   );

   task automatic clear_in();
      ren_bundle = '0;
      red_bundle = '0;
      wb_valid   = '0;
      wb_prd     = '0;
      rob_free   = 6'd32;
      iq_free    = {4{4'd8}};
   endtask

   task automatic slot(input int i, input logic [15:0] opid, input logic [5:0] a0,
                       input logic [5:0] a1, input logic [5:0] d1, input logic [3:0] fu);
      ren_bundle[i]         = '0;
      ren_bundle[i].opid    = opid;
      ren_bundle[i].prsa[0] = a0;
      ren_bundle[i].prsa[1] = a1;
      ren_bundle[i].prda[1] = d1;
      ren_bundle[i].fu      = fu;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_in();
      #2 rst = 1'b0;
      slot(0, 16'h8001, 0, 0, 3, 0);
      repeat (2) @(posedge clk);
      #1;
      n_total++; if (rename !== 2'b00) $display("FAIL reset_rename got %b want 00", rename); else n_pass++;
      n_total++; if ({dis_bundle[1].opid, dis_bundle[0].opid} !== 32'h0) $display("FAIL reset_opid got %h want 0", {dis_bundle[1].opid, dis_bundle[0].opid}); else n_pass++;
      n_total++; if (dis_rdy !== 4'b0) $display("FAIL reset_rdy got %b want 0", dis_rdy); else n_pass++;
      n_total++; if (dut.r_busy !== 64'h0) $display("FAIL reset_busy got %h want 0", dut.r_busy); else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      clear_in();
   endtask

   task automatic test_intra_dep();
      @(negedge clk);
      clear_in();
      slot(0, 16'h8001, 0, 0, 5, 0);
      slot(1, 16'h8002, 5, 0, 6, 1);
      #1;
      n_total++; if (rename !== 2'b11) $display("FAIL dep_rename got %b want 11", rename); else n_pass++;
      sb.push_back('{32'h8002_8001, 4'b1011});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_total++; if ({dis_bundle[1].opid, dis_bundle[0].opid} !== e.opids) $display("FAIL dep_opid got %h want %h", {dis_bundle[1].opid, dis_bundle[0].opid}, e.opids); else n_pass++;
      n_total++; if (dis_rdy !== e.rdy) $display("FAIL dep_rdy got %b want %b", dis_rdy, e.rdy); else n_pass++;
      n_total++; if (dut.r_busy[6:5] !== 2'b11) $display("FAIL dep_busy got %b want 11", dut.r_busy[6:5]); else n_pass++;
   endtask

   task automatic test_wb_bypass();
      @(negedge clk);
      clear_in();
      slot(0, 16'h8003, 5, 6, 0, 2);
      wb_valid  = 2'b01;
      wb_prd[0] = 6'd5;
      #1;
      n_total++; if (rename !== 2'b01) $display("FAIL wb_rename got %b want 01", rename); else n_pass++;
      sb.push_back('{32'h0000_8003, 4'b0001});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_total++; if ({dis_bundle[1].opid, dis_bundle[0].opid} !== e.opids) $display("FAIL wb_opid got %h want %h", {dis_bundle[1].opid, dis_bundle[0].opid}, e.opids); else n_pass++;
      n_total++; if (dis_rdy !== e.rdy) $display("FAIL wb_rdy got %b want %b", dis_rdy, e.rdy); else n_pass++;
      n_total++; if (dut.r_busy[6:5] !== 2'b10) $display("FAIL wb_busy got %b want 10", dut.r_busy[6:5]); else n_pass++;
      // intra-group producer overrides a same-cycle writeback; set beats clear
      @(negedge clk);
      clear_in();
      slot(0, 16'h8004, 6, 0, 7, 0);
      slot(1, 16'h8005, 7, 0, 0, 0);
      wb_valid  = 2'b11;
      wb_prd[0] = 6'd6;
      wb_prd[1] = 6'd7;
      #1;
      n_total++; if (rename !== 2'b11) $display("FAIL ovr_rename got %b want 11", rename); else n_pass++;
      sb.push_back('{32'h8005_8004, 4'b1011});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_total++; if ({dis_bundle[1].opid, dis_bundle[0].opid} !== e.opids) $display("FAIL ovr_opid got %h want %h", {dis_bundle[1].opid, dis_bundle[0].opid}, e.opids); else n_pass++;
      n_total++; if (dis_rdy !== e.rdy) $display("FAIL ovr_rdy got %b want %b", dis_rdy, e.rdy); else n_pass++;
      n_total++; if (dut.r_busy[7:6] !== 2'b10) $display("FAIL ovr_busy got %b want 10", dut.r_busy[7:6]); else n_pass++;
   endtask

   task automatic test_rob_credit();
      logic [5:0]  frees [3] = '{6'd1, 6'd1, 6'd2};
      logic [1:0]  rens  [3] = '{2'b00, 2'b01, 2'b01};
      logic [15:0] op0   [3] = '{16'h8010, 16'h8010, 16'h8012};
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         clear_in();
         rob_free = frees[c];
         slot(0, op0[c], 0, 0, 0, 0);
         slot(1, 16'h8011, 0, 0, 0, 1);
         #1;
         n_total++; if (rename !== rens[c]) $display("FAIL rob_rename[%0d] got %b want %b", c, rename, rens[c]); else n_pass++;
         if (rens[c] == 2'b01) sb.push_back('{{16'h0, op0[c]}, 4'b0011});
         else sb.push_back('{32'h0, 4'b0000});
         @(posedge clk); #1;
         e = sb.pop_front();
         n_total++; if ({dis_bundle[1].opid, dis_bundle[0].opid} !== e.opids) $display("FAIL rob_opid[%0d] got %h want %h", c, {dis_bundle[1].opid, dis_bundle[0].opid}, e.opids); else n_pass++;
      end
   endtask

   task automatic test_credit_held();
      logic [3:0]  qf   [3] = '{4'd8, 4'd1, 4'd1};
      logic [1:0]  rens [3] = '{2'b01, 2'b00, 2'b01};
      logic [15:0] op0  [3] = '{16'h8020, 16'h8021, 16'h8021};
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         clear_in();
         iq_free[2] = qf[c];
         slot(0, op0[c], 0, 0, 0, 2);
         if (c > 0) slot(1, 16'h8022, 0, 0, 0, 2);
         #1;
         n_total++; if (rename !== rens[c]) $display("FAIL iq_rename[%0d] got %b want %b", c, rename, rens[c]); else n_pass++;
         if (rens[c] == 2'b01) sb.push_back('{{16'h0, op0[c]}, 4'b0011});
         else sb.push_back('{32'h0, 4'b0000});
         @(posedge clk); #1;
         e = sb.pop_front();
         n_total++; if ({dis_bundle[1].opid, dis_bundle[0].opid} !== e.opids) $display("FAIL iq_opid[%0d] got %h want %h", c, {dis_bundle[1].opid, dis_bundle[0].opid}, e.opids); else n_pass++;
      end
   endtask

   task automatic test_in_order_stop();
      @(negedge clk);
      clear_in();
      iq_free[3] = 4'd0;
      slot(0, 16'h8030, 0, 0, 0, 3);
      slot(1, 16'h8031, 0, 0, 0, 0);
      #1;
      n_total++; if (rename !== 2'b00) $display("FAIL stop_rename got %b want 00", rename); else n_pass++;
      sb.push_back('{32'h0, 4'b0000});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_total++; if ({dis_bundle[1].opid, dis_bundle[0].opid} !== e.opids) $display("FAIL stop_opid got %h want %h", {dis_bundle[1].opid, dis_bundle[0].opid}, e.opids); else n_pass++;
   endtask

   task automatic test_redirect();
      @(negedge clk);
      clear_in();
      slot(0, 16'h8040, 0, 0, 0, 1);
      #1;
      n_total++; if (rename !== 2'b01) $display("FAIL red_pre_rename got %b want 01", rename); else n_pass++;
      sb.push_back('{32'h0000_8040, 4'b0011});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_total++; if ({dis_bundle[1].opid, dis_bundle[0].opid} !== e.opids) $display("FAIL red_held got %h want %h", {dis_bundle[1].opid, dis_bundle[0].opid}, e.opids); else n_pass++;
      red_bundle.opid = 16'h8000;
      slot(0, 16'h8041, 0, 0, 0, 1);
      #1;
      n_total++; if ({dis_bundle[1].opid, dis_bundle[0].opid} !== 32'h0) $display("FAIL red_force got %h want 0", {dis_bundle[1].opid, dis_bundle[0].opid}); else n_pass++;
      n_total++; if (rename !== 2'b00) $display("FAIL red_rename got %b want 00", rename); else n_pass++;
      sb.push_back('{32'h0, 4'b0000});
      @(posedge clk); #1;
      clear_in();
      #1;
      e = sb.pop_front();
      n_total++; if ({dis_bundle[1].opid, dis_bundle[0].opid} !== e.opids) $display("FAIL red_after got %h want %h", {dis_bundle[1].opid, dis_bundle[0].opid}, e.opids); else n_pass++;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         clear_in();
         red_bundle.rollback = 1'b1;
         slot(0, 16'h8050, 0, 0, 0, 0);
         #1;
         n_total++; if (rename !== 2'b00) $display("FAIL rb_rename[%0d] got %b want 00", c, rename); else n_pass++;
         sb.push_back('{32'h0, 4'b0000});
         @(posedge clk); #1;
         e = sb.pop_front();
         n_total++; if ({dis_bundle[1].opid, dis_bundle[0].opid} !== e.opids) $display("FAIL rb_opid[%0d] got %h want %h", c, {dis_bundle[1].opid, dis_bundle[0].opid}, e.opids); else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      clear_in();
      slot(0, 16'h8060, 0, 0, 9, 0);
      #1;
      n_total++; if (rename !== 2'b01) $display("FAIL ar_pre_rename got %b want 01", rename); else n_pass++;
      @(posedge clk); #2;
      n_total++; if ({dut.r_busy[9], dis_bundle[0].opid} !== {1'b1, 16'h8060}) $display("FAIL ar_pre_state got %h want %h", {dut.r_busy[9], dis_bundle[0].opid}, {1'b1, 16'h8060}); else n_pass++;
      rst = 1'b0;
      #1;
      n_total++; if ({dis_bundle[1].opid, dis_bundle[0].opid} !== 32'h0) $display("FAIL ar_opid got %h want 0", {dis_bundle[1].opid, dis_bundle[0].opid}); else n_pass++;
      n_total++; if (dis_rdy !== 4'b0) $display("FAIL ar_rdy got %b want 0", dis_rdy); else n_pass++;
      n_total++; if (dut.r_busy !== 64'h0) $display("FAIL ar_busy got %h want 0", dut.r_busy); else n_pass++;
      n_total++; if (rename !== 2'b00) $display("FAIL ar_rename got %b want 00", rename); else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      clear_in();
   endtask

   initial begin
      test_reset();
      test_intra_dep();
      test_wb_bypass();
      test_rob_credit();
      test_credit_held();
      test_in_order_stop();
      test_redirect();
      test_async_reset();
      n_total++; if (sb.size() != 0) $display("FAIL sb_drain got %0d want 0", sb.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
